// File: rtl/axil_pkg.sv
// Shared response codes and FSM state type for the AXI4-Lite master.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } axil_state_t;

endpackage

// File: rtl/axil_timeout_ctr.sv
// Saturating cycle counter that flags when an outstanding transaction has waited MAX cycles.
// Only instantiated when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_timeout_ctr
  import axil_pkg::*;
#(
  parameter int MAX = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count;

  assign expired = (count == W'(MAX));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master bridging a simple host command/response interface.
// Optional debug abort timer compiled in with AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master
  import axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  axil_state_t state, state_next;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done;
  logic        w_done;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic abort;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign aw_fire  = awvalid && awready;
  assign w_fire   = wvalid && wready;
  assign b_fire   = bvalid && bready;
  assign ar_fire  = arvalid && arready;
  assign r_fire   = rvalid && rready;

  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic busy;
  logic expired;
  logic timeout_q;

  assign busy = (state == WR_REQ) || (state == WR_RESP) ||
                (state == RD_REQ) || (state == RD_DATA);

  axil_timeout_ctr #(
    .MAX(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (cmd_fire),
    .enable  (busy),
    .expired (expired)
  );

  // A handshake completing on the expiry cycle wins over the abort.
  assign abort       = busy && expired && !b_fire && !r_fire;
  assign rsp_timeout = timeout_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timeout_q <= 1'b0;
    end else if (cmd_fire) begin
      timeout_q <= 1'b0;
    end else if (abort) begin
      timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign abort       = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= OKAY;
    end else begin
      state <= state_next;
      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (b_fire) begin
        resp_q  <= bresp;
        rdata_q <= '0;
      end
      if (r_fire) begin
        resp_q  <= rresp;
        rdata_q <= rdata;
      end
      if (abort) begin
        resp_q  <= SLVERR;
        rdata_q <= '0;
      end
    end
  end

  // Valids depend only on state and handshake history, never on a ready.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = aresetn;
        if (cmd_valid && aresetn) state_next = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if (aw_done && w_done) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_next = DONE;
      end
      RD_REQ: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_next = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = DONE;
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed cases plus randomized transactions
// against a latency/response model derived from the handshake rules.
module tb_axi_lite_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks   = 0;
  int failures = 0;
  int cyc;

  always #5 aclk = ~aclk;

  axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic checkOutput(input string tag, input string item,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, item, observed, expected);
    end
  endtask

  task automatic clearSlave();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, "ctrl", {24'd0, cmd_ready, rsp_valid, rsp_timeout, awvalid,
                              wvalid, bready, arvalid, rready}, 32'd0);
    checkOutput(tag, "awaddr", awaddr, 32'd0);
    checkOutput(tag, "wdata", wdata, 32'd0);
    checkOutput(tag, "araddr", araddr, 32'd0);
    checkOutput(tag, "rsp_rdata", rsp_rdata, 32'd0);
    checkOutput(tag, "wstrb_resp", {26'd0, wstrb, rsp_resp}, 32'd0);
  endtask

  // One full transaction; the slave delays each ready/valid by the given cycle counts.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [3:0] strb,
                               input int aw_d, input int w_d, input int b_d,
                               input int ar_d, input int r_d,
                               input logic [1:0] s_resp, input logic [31:0] s_rdata,
                               input int hold);
    int c, lat, aw_hi, w_hi, ar_hi, aw_hs, w_hs, b_hs, ar_hs, r_hs, b_wait, r_wait;
    int exp_lat;
    logic [31:0] exp_rdata;
    exp_rdata = wr ? 32'd0 : s_rdata;
    exp_lat   = wr ? (((aw_d > w_d) ? aw_d : w_d) + 4 + b_d) : (ar_d + 3 + r_d);
    {aw_hi, w_hi, ar_hi, aw_hs, w_hs, b_hs, ar_hs, r_hs, b_wait, r_wait} = '0;

    @(negedge aclk);
    checkOutput(tag, "cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    @(posedge aclk); #1;
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

    c = 0; lat = -1;
    while (lat < 0 && c < 300) begin
      @(negedge aclk);
      c++;
      if (rsp_valid) begin
        lat = c;
      end else begin
        awready = awvalid && (aw_hi >= aw_d);
        wready  = wvalid && (w_hi >= w_d);
        arready = arvalid && (ar_hi >= ar_d);
        bvalid  = bready && (b_wait >= b_d);
        bresp   = s_resp;
        rvalid  = rready && (r_wait >= r_d);
        rresp   = s_resp;
        rdata   = s_rdata;
        if (awvalid) begin
          aw_hi++;
          if (awaddr !== addr || awaddr === 32'hx) aw_hs += 100;
        end
        if (wvalid) begin
          w_hi++;
          if (wdata !== wd || wstrb !== strb) w_hs += 100;
        end
        if (arvalid) begin
          ar_hi++;
          if (araddr !== addr) ar_hs += 100;
        end
        if (bready) b_wait++;
        if (rready) r_wait++;
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready)   w_hs++;
        if (bvalid && bready)   b_hs++;
        if (arvalid && arready) ar_hs++;
        if (rvalid && rready)   r_hs++;
      end
    end
    clearSlave();

    checkOutput(tag, "latency", lat, exp_lat);
    if (wr) begin
      checkOutput(tag, "aw_cycles", aw_hi, aw_d + 1);
      checkOutput(tag, "w_cycles", w_hi, w_d + 1);
      checkOutput(tag, "aw_handshakes", aw_hs, 1);
      checkOutput(tag, "w_handshakes", w_hs, 1);
      checkOutput(tag, "b_handshakes", b_hs, 1);
    end else begin
      checkOutput(tag, "ar_cycles", ar_hi, ar_d + 1);
      checkOutput(tag, "ar_handshakes", ar_hs, 1);
      checkOutput(tag, "r_handshakes", r_hs, 1);
    end

    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge aclk);
      checkOutput(tag, "rsp_valid", rsp_valid, 1);
      checkOutput(tag, "rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput(tag, "rsp_resp", rsp_resp, s_resp);
      checkOutput(tag, "rsp_timeout", rsp_timeout, 0);
      checkOutput(tag, "cmd_ready_busy", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(posedge aclk); #1;
    rsp_ready = 0;
    checkOutput(tag, "cmd_ready_after", cmd_ready, 1);
    checkOutput(tag, "rsp_valid_after", rsp_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; rsp_ready = 0;
    clearSlave();
    repeat (3) @(posedge aclk);
    #1 checkAllZero("reset");
    @(negedge aclk) aresetn = 1;
    @(posedge aclk); #1;
    checkOutput("reset_release", "cmd_ready", cmd_ready, 1);

    $display("[TB] directed transactions");
    applyStimulus("wr_basic", 1, 32'h8, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    applyStimulus("rd_basic", 0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'b00, 32'h1234_5678, 0);
    applyStimulus("wr_w_first", 1, 32'h10, 32'hDEAD_BEEF, 4'h3, 2, 0, 1, 0, 0, 2'b00, 32'h0, 0);
    applyStimulus("wr_same", 1, 32'h14, 32'h0BAD_F00D, 4'hC, 1, 1, 0, 0, 0, 2'b01, 32'h0, 0);
    applyStimulus("wr_aw_first", 1, 32'hFFFF_FFFD, 32'h1, 4'h5, 0, 3, 2, 0, 0, 2'b11, 32'h0, 1);
    applyStimulus("rd_slverr", 0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 1, 2, 2'b10, 32'hCAFE_0042, 5);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 12; i++) begin
      applyStimulus("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    2'($urandom), $urandom, $urandom_range(0, 3));
    end

    $display("[TB] reset during read data phase");
    @(negedge aclk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
    @(posedge aclk); #1 cmd_valid = 0;
    @(negedge aclk) arready = 1;
    @(negedge aclk) arready = 0;
    checkOutput("rst_mid", "rready", rready, 1);
    #2 aresetn = 0;
    #1 checkAllZero("rst_mid");
    @(negedge aclk) aresetn = 1;
    @(posedge aclk); #1;
    checkOutput("rst_mid", "cmd_ready_first", cmd_ready, 1);
    checkOutput("rst_mid", "rsp_valid_first", rsp_valid, 0);

    $display("[TB] write with no B response");
    @(negedge aclk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h80; cmd_wdata = 32'h5; cmd_wstrb = 4'hF;
    @(posedge aclk); #1 cmd_valid = 0;
    awready = 1; wready = 1;
`ifdef AXIL_MASTER_TIMEOUT_EN
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge aclk);
      cyc++;
    end
    clearSlave();
    checkOutput("timeout", "rsp_valid", rsp_valid, 1);
    checkOutput("timeout", "window", (cyc >= 16 && cyc <= 20), 1);
    checkOutput("timeout", "rsp_timeout", rsp_timeout, 1);
    checkOutput("timeout", "rsp_resp", rsp_resp, 2'b10);
    checkOutput("timeout", "rsp_rdata", rsp_rdata, 0);
    checkOutput("timeout", "bready", bready, 0);
    rsp_ready = 1;
    @(posedge aclk); #1 rsp_ready = 0;
    checkOutput("timeout", "cmd_ready_after", cmd_ready, 1);
`else
    repeat (40) @(negedge aclk);
    clearSlave();
    checkOutput("no_timeout", "bready", bready, 1);
    checkOutput("no_timeout", "rsp_valid", rsp_valid, 0);
    checkOutput("no_timeout", "rsp_timeout", rsp_timeout, 0);
    checkOutput("no_timeout", "cmd_ready", cmd_ready, 0);
    aresetn = 0;
    @(negedge aclk) aresetn = 1;
    @(posedge aclk); #1;
    checkOutput("no_timeout", "cmd_ready_after_rst", cmd_ready, 1);
`endif

    applyStimulus("rd_final", 0, 32'h7, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h89AB_CDEF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
